// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: assembles little-endian words into instruction memory and holds
// the core in reset until the image checksum passes. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module imem_boot_loader #(
    parameter int unsigned NB_WORD        = 32,
    parameter int unsigned NB_IMEM_ADDR   = 10,
    parameter int unsigned IMEM_DEPTH     = 1024,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int unsigned RELEASE_DELAY  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_rx_valid,
    input  logic [7:0]              i_rx_data,
    output logic                    o_rx_ready,
    input  logic                    i_rearm,
    output logic                    o_imem_we,
    output logic [NB_IMEM_ADDR-1:0] o_imem_addr,
    output logic [NB_WORD-1:0]      o_imem_wdata,
    output logic                    o_cpu_reset,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [1:0]              o_err_code
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StRelease,
        StRun,
        StError
    } state_t;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrLen     = 2'b01;
    localparam logic [1:0] ErrCsum    = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    // The length field is 16 bits, so the word index is kept at that width.
    if (NB_WORD != 32 || RELEASE_DELAY < 1 || TIMEOUT_CYCLES < 1 || NB_IMEM_ADDR > 16 ||
        IMEM_DEPTH > (1 << NB_IMEM_ADDR)) begin : g_bad_params
        $error("imem_boot_loader: unsupported parameter set");
    end

    state_t                  r_state;
    state_t                  w_state_d;
    logic                    r_rx_ready;
    logic                    w_accept;
    logic                    w_in_frame;
    logic [7:0]              r_len_lo;
    logic [15:0]             r_len;
    logic [15:0]             w_len;
    logic                    w_len_bad;
    logic [15:0]             r_word_idx;
    logic                    w_last_word;
    logic [1:0]              r_lane;
    logic [23:0]             r_lanes;
    logic [7:0]              r_sum;
    logic [15:0]             r_rel_cnt;
    logic                    w_rel_done;
    logic [1:0]              r_err_code;
    logic [1:0]              w_err_code_d;
    logic                    w_rearm;
    logic                    w_tmo_hit;
    logic                    r_imem_we;
    logic [NB_IMEM_ADDR-1:0] r_imem_addr;
    logic [NB_WORD-1:0]      r_imem_wdata;

    assign w_accept    = i_rx_valid && r_rx_ready;
    assign w_in_frame  = (r_state == StLenLo) || (r_state == StLenHi) ||
                         (r_state == StData)  || (r_state == StCsum);
    assign w_len       = {i_rx_data, r_len_lo};
    assign w_len_bad   = (w_len == 16'd0) || ({16'd0, w_len} > IMEM_DEPTH);
    assign w_last_word = (r_word_idx == (r_len - 16'd1));
    assign w_rel_done  = (r_rel_cnt == 16'(RELEASE_DELAY - 1));
    assign w_rearm     = i_rearm && ((r_state == StRun) || (r_state == StError));

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;

    // Counts idle cycles inside a frame; any accepted byte restarts it.
    always_ff @(posedge i_clock) begin
        if (i_reset || w_accept || !w_in_frame) begin
            r_tmo_cnt <= 32'd0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
    end

    assign w_tmo_hit = w_in_frame && !w_accept && (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_err_code_d = r_err_code;
        unique case (r_state)
            StIdle: begin
                if (w_accept && (i_rx_data == MAGIC)) begin
                    w_state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (w_accept) begin
                    w_state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (w_accept) begin
                    if (w_len_bad) begin
                        w_state_d    = StError;
                        w_err_code_d = ErrLen;
                    end else begin
                        w_state_d = StData;
                    end
                end
            end
            StData: begin
                if (w_accept && (r_lane == 2'd3) && w_last_word) begin
                    w_state_d = StCsum;
                end
            end
            StCsum: begin
                if (w_accept) begin
                    if (i_rx_data == r_sum) begin
                        w_state_d = StRelease;
                    end else begin
                        w_state_d    = StError;
                        w_err_code_d = ErrCsum;
                    end
                end
            end
            StRelease: begin
                if (w_rel_done) begin
                    w_state_d = StRun;
                end
            end
            StRun, StError: begin
                if (i_rearm) begin
                    w_state_d    = StIdle;
                    w_err_code_d = ErrNone;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        if (w_tmo_hit) begin
            w_state_d    = StError;
            w_err_code_d = ErrTimeout;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_rx_ready   <= 1'b1;
            r_err_code   <= ErrNone;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_word_idx   <= 16'd0;
            r_lane       <= 2'd0;
            r_lanes      <= 24'd0;
            r_sum        <= 8'd0;
            r_rel_cnt    <= 16'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_state    <= w_state_d;
            r_rx_ready <= (w_state_d inside {StIdle, StLenLo, StLenHi, StData, StCsum});
            r_err_code <= w_err_code_d;
            r_imem_we  <= 1'b0;
            case (r_state)
                StLenLo: begin
                    if (w_accept) begin
                        r_len_lo <= i_rx_data;
                    end
                end
                StLenHi: begin
                    if (w_accept) begin
                        r_len      <= w_len;
                        r_word_idx <= 16'd0;
                        r_lane     <= 2'd0;
                        r_sum      <= 8'd0;
                    end
                end
                StData: begin
                    if (w_accept) begin
                        r_sum  <= r_sum + i_rx_data;
                        r_lane <= r_lane + 2'd1;
                        unique case (r_lane)
                            2'd0: r_lanes[7:0]   <= i_rx_data;
                            2'd1: r_lanes[15:8]  <= i_rx_data;
                            2'd2: r_lanes[23:16] <= i_rx_data;
                            2'd3: begin
                                // Word is complete: strobe it out while the next byte streams in.
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= r_word_idx[NB_IMEM_ADDR-1:0];
                                r_imem_wdata <= NB_WORD'({i_rx_data, r_lanes});
                                r_word_idx   <= r_word_idx + 16'd1;
                            end
                            default: ;
                        endcase
                    end
                end
                StCsum: begin
                    r_rel_cnt <= 16'd0;
                end
                StRelease: begin
                    r_rel_cnt <= r_rel_cnt + 16'd1;
                end
                default: ;
            endcase
            if (w_rearm) begin
                r_len_lo   <= 8'd0;
                r_len      <= 16'd0;
                r_word_idx <= 16'd0;
                r_lane     <= 2'd0;
                r_sum      <= 8'd0;
                r_rel_cnt  <= 16'd0;
            end
        end
    end

    assign o_rx_ready   = r_rx_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_cpu_reset  = (r_state != StRun);
    assign o_busy       = w_in_frame;
    assign o_done       = (r_state == StRun);
    assign o_error      = (r_state == StError);
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized frames checked
// against a frame-parsing reference model; timeout cases run when LOADER_TIMEOUT_EN is defined.
module tb_imem_boot_loader;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    localparam logic [7:0] MAGIC = 8'hA5;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rearm;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        prev_we = 1'b0;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_rx_ready  (rx_ready),
        .i_rearm     (rearm),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_wdata(imem_wdata),
        .o_cpu_reset (cpu_reset),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_err_code  (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor; a strobe must never last two cycles.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            chk("we_single_cycle", 32'(prev_we), 32'd0);
            wr_addr_q.push_back(32'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
        prev_we = imem_we;
    end

    // gap < 0: random 0..2 idle cycles before the byte; otherwise exactly gap idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        int g;
        n = 0;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        forever begin
            @(negedge clk);
            if (rx_ready === 1'b1) break;
            n++;
            if (n >= 200) break;
        end
        if (rx_ready !== 1'b1) begin
            chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input byte_q_t fr, input int gap);
        wr_addr_q = {};
        wr_data_q = {};
        foreach (fr[i]) send_byte(fr[i], gap);
    endtask

    task automatic gen_frame(input int len, input bit corrupt, output byte_q_t fr);
        logic [7:0] b;
        logic [7:0] s;
        fr = {};
        s  = 8'd0;
        repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom);
            if (b == MAGIC) b = 8'h00;
            fr.push_back(b);
        end
        fr.push_back(MAGIC);
        fr.push_back(8'(len));
        fr.push_back(8'(len >> 8));
        if (len >= 1 && len <= DEPTH) begin
            for (int i = 0; i < 4 * len; i++) begin
                b = 8'($urandom);
                fr.push_back(b);
                s = s + b;
            end
            fr.push_back(corrupt ? s + 8'($urandom_range(1, 255)) : s);
        end
    endtask

    // Reference: parse the frame as the format describes it.
    task automatic model_frame(input byte_q_t fr, output word_q_t exp_w, output int exp_code);
        int i;
        int len;
        logic [7:0]  s;
        logic [31:0] word;
        exp_w = {};
        i = 0;
        s = 8'd0;
        while (fr[i] != MAGIC) i++;
        len = int'(fr[i+1]) + 256 * int'(fr[i+2]);
        if (len == 0 || len > DEPTH) begin
            exp_code = 1;
            return;
        end
        for (int w = 0; w < len; w++) begin
            word = 32'd0;
            for (int k = 0; k < 4; k++) begin
                word = word + (32'(fr[i + 3 + 4 * w + k]) << (8 * k));
                s = s + fr[i + 3 + 4 * w + k];
            end
            exp_w.push_back(word);
        end
        exp_code = (fr[i + 3 + 4 * len] == s) ? 0 : 2;
    endtask

    task automatic check_frame(input string tag, input word_q_t exp_w, input int exp_code);
        int n;
        chk({tag, "_nwrites"}, 32'(wr_data_q.size()), 32'(exp_w.size()));
        foreach (exp_w[i]) begin
            if (i < wr_data_q.size()) begin
                chk({tag, "_addr"}, wr_addr_q[i], 32'(i));
                chk({tag, "_data"}, wr_data_q[i], exp_w[i]);
            end
        end
        if (exp_code == 0) begin
            n = 0;
            while (cpu_reset === 1'b1 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk({tag, "_release_delay"}, 32'(n), 32'd4);
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_ready_run"}, 32'(rx_ready), 32'd0);
            chk({tag, "_err_run"}, 32'(error), 32'd0);
        end else begin
            chk({tag, "_error"}, 32'(error), 32'd1);
            chk({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
            chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
            chk({tag, "_ready_err"}, 32'(rx_ready), 32'd0);
        end
    endtask

    task automatic do_rearm(input string tag);
        rearm = 1'b1;
        @(posedge clk);
        #1;
        rearm = 1'b0;
        chk({tag, "_rearm_error"}, 32'(error), 32'd0);
        chk({tag, "_rearm_done"}, 32'(done), 32'd0);
        chk({tag, "_rearm_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_rearm_ready"}, 32'(rx_ready), 32'd1);
        chk({tag, "_rearm_code"}, 32'(err_code), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_ready"}, 32'(rx_ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t fr;
        word_q_t exp_w;
        int      code;
        int      len;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rearm    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Directed good frame with leading junk.
        fr = '{8'h00, 8'h13, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'hBB};
        send_frame(fr, -1);
        exp_w = '{32'h00000513, 32'h00100093};
        check_frame("dir_good", exp_w, 0);
        do_rearm("dir_good");

        fr = '{8'hA5, 8'h00, 8'h00};
        send_frame(fr, -1);
        exp_w = {};
        check_frame("len_zero", exp_w, 1);
        do_rearm("len_zero");

        fr = '{8'hA5, 8'h01, 8'h04};
        send_frame(fr, -1);
        check_frame("len_1025", exp_w, 1);
        do_rearm("len_1025");

        fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        send_frame(fr, -1);
        exp_w = '{32'h04030201};
        check_frame("bad_csum", exp_w, 2);
        do_rearm("bad_csum");

        // Randomized frames: small good ones, a corrupted one, an oversize length,
        // and a full-depth back-to-back image.
        for (int k = 0; k < 7; k++) begin
            case (k)
                3:       len = int'($urandom_range(1025, 65535));
                5:       len = DEPTH;
                default: len = 1 + int'($urandom_range(0, 5));
            endcase
            gen_frame(len, (k == 2), fr);
            model_frame(fr, exp_w, code);
            send_frame(fr, (k == 1 || k == 5) ? 0 : -1);
            check_frame($sformatf("rand%0d", k), exp_w, code);
            do_rearm($sformatf("rand%0d", k));
        end

        // Reset in the middle of the payload.
        fr = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(fr, -1);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("mid_reset");
        gen_frame(2, 1'b0, fr);
        model_frame(fr, exp_w, code);
        send_frame(fr, -1);
        check_frame("after_reset", exp_w, code);
        do_rearm("after_reset");

`ifdef LOADER_TIMEOUT_EN
        fr = '{8'hA5, 8'h02, 8'h00};
        send_frame(fr, 0);
        repeat (49) begin
            @(posedge clk);
            #1;
        end
        chk("tmo_49_no_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        chk("tmo_50_error", 32'(error), 32'd1);
        chk("tmo_50_code", 32'(err_code), 32'd3);
        do_rearm("tmo");

        gen_frame(1, 1'b0, fr);
        model_frame(fr, exp_w, code);
        send_frame(fr, 49);
        check_frame("tmo_stall49", exp_w, code);
        do_rearm("tmo_stall49");

        repeat (120) begin
            @(posedge clk);
            #1;
        end
        chk("tmo_idle_error", 32'(error), 32'd0);
        chk("tmo_idle_ready", 32'(rx_ready), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Byte-stream program loader that sits upstream of the RV32I core.
- Receives a framed program image, for example from a UART receiver, over a valid/ready byte interface.
- Assembles 32-bit little-endian words and writes them sequentially into instruction memory through the memory's write port.
- Holds the core in reset until a complete image passes its checksum, then releases it.

Parameters:
NB_WORD, 32, instruction/data word width (fixed at 32 for RV32I)
NB_IMEM_ADDR, 10, instruction memory word-address width
IMEM_DEPTH, 1024, instruction memory depth in words; must be <= 2**NB_IMEM_ADDR
MAGIC, 8'hA5, frame start byte
RELEASE_DELAY, 4, cycles between checksum pass and core reset deassertion (>=1)
TIMEOUT_CYCLES, 100000, inter-byte timeout (used only with LOADER_TIMEOUT_EN)

Ports:
i_clock  input  1  clock
i_reset  input  1  reset: synchronous, active-high; clock i_clock
i_rx_valid  input  1  byte available
i_rx_data  input  8  byte value
o_rx_ready  output  1  loader accepts byte; a transfer occurs when i_rx_valid && o_rx_ready
i_rearm  input  1  single-cycle request to reload; honoured only in RUN or ERROR
o_imem_we  output  1  imem write strobe, one cycle per word
o_imem_addr  output  NB_IMEM_ADDR  imem word address
o_imem_wdata  output  NB_WORD  imem write data
o_cpu_reset  output  1  reset to the core, active-high
o_busy  output  1  frame reception in progress (LEN_LO..CSUM)
o_done  output  1  image loaded, core running
o_error  output  1  frame rejected
o_err_code  output  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout

Behaviour:
- Reset values:
  - o_cpu_reset=1, o_rx_ready=1; all other outputs 0.
  - State=IDLE; word counter, byte counter and checksum cleared.
- Frame format: MAGIC, LEN_LO, LEN_HI (16-bit word count L), then L*4 payload bytes (little-endian per word), then CSUM = 8-bit sum mod 256 of all payload bytes.
- States and transitions (each transition consumes one accepted byte unless noted):
  - IDLE: byte==MAGIC -> LEN_LO. Any other byte is discarded; stay.
  - LEN_LO: latch low byte -> LEN_HI.
  - LEN_HI: latch high byte.
    - L==0 or L>IMEM_DEPTH -> ERROR with code 01.
    - Otherwise -> DATA with word index 0, byte lane 0, sum 0.
  - DATA: place byte in lane 0..3 (lane 0 = bits 7:0) and add it to the sum.
    - The cycle after lane 3 is accepted: o_imem_we=1 for exactly one cycle, o_imem_addr=word index, o_imem_wdata=assembled word. Word index then increments.
    - After word L-1 is accepted -> CSUM.
  - CSUM: byte==sum -> RELEASE; mismatch -> ERROR with code 10.
  - RELEASE: o_rx_ready=0. Count RELEASE_DELAY cycles, then -> RUN.
  - RUN: o_cpu_reset=0, o_done=1, o_rx_ready=0.
  - ERROR: o_error=1, o_err_code held, o_cpu_reset=1, o_rx_ready=0.
  - RUN or ERROR with i_rearm=1 -> IDLE next cycle:
    - o_cpu_reset=1 in that cycle.
    - Counters, sum, o_err_code, o_done and o_error cleared.
- o_rx_ready is 1 in IDLE, LEN_LO, LEN_HI, DATA and CSUM; it is registered from the state.
- Writes are back-to-back capable: a byte is accepted every cycle while a write strobe is issued for the previous word.
- o_imem_addr and o_imem_wdata hold their last values when o_imem_we=0.
- i_rearm is ignored in states IDLE..RELEASE.
- i_reset asserted mid-frame: abort to reset values. Partially written imem contents are not cleared.
- Word index wraps only at IMEM_DEPTH, which cannot be reached because of the length check.

Optional Feature:
LOADER_TIMEOUT_EN
- Defined:
  - A counter runs while in LEN_LO, LEN_HI, DATA or CSUM. It restarts on every accepted byte.
  - Reaching TIMEOUT_CYCLES cycles without an accepted byte -> ERROR with code 11.
  - IDLE never times out.
- Undefined: no counter exists; the loader waits indefinitely and code 11 is never produced.

Test Plan:
- Reset -> o_cpu_reset=1, o_rx_ready=1, o_done=0, o_error=0, o_err_code=00.
- Bytes 00,13,A5,02,00,13,05,00,00,93,00,10,00,BB:
  - Leading 00,13 are discarded.
  - Writes addr0=32'h00000513, addr1=32'h00100093, one cycle each.
  - CSUM BB matches (13+05+93+10=BB mod 256).
  - o_cpu_reset falls exactly RELEASE_DELAY=4 cycles after CSUM is accepted; o_done=1.
- A5,00,00 -> ERROR code 01, zero writes. Separately, A5,01,04 (L=1025) -> ERROR code 01.
- Valid frame with L=1, payload 01,02,03,04 and CSUM 0B (expected 0A) -> word write still occurs; ERROR code 10; o_cpu_reset stays 1.
- From ERROR, pulse i_rearm -> IDLE next cycle with o_error=0. Resend a good frame -> RUN. i_reset asserted during DATA -> all outputs return to reset values.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=50:
  - Stall 50 cycles after LEN_HI -> ERROR code 11.
  - Stalls of 49 cycles between bytes -> no error.
  - Stall in IDLE -> no error.
